// File: rtl/accel_weight_load_seq.sv
// accel_weight_load_seq
// Fetches an R x S filter from memory one word at a time and writes each
// word into the PE array weight registers in row-major order.
// Optional build macro ACCEL_WLOAD_STALL_CNT_EN adds the wload_stall_cycles
// output, which counts memory back-pressure cycles during a load.

module accel_weight_load_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int PE_ROWS    = 5,
    parameter int PE_COLS    = 5
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  start,
    input  logic [3:0]            param_R,
    input  logic [3:0]            param_S,
    input  logic [ADDR_WIDTH-1:0] weight_base_addr,
    output logic                  rd_req_valid,
    input  logic                  rd_req_ready,
    output logic [ADDR_WIDTH-1:0] rd_req_addr,
    input  logic                  rd_rsp_valid,
    input  logic [DATA_WIDTH-1:0] rd_rsp_data,
    output logic                  wt_wr_en,
    output logic [2:0]            weight_row_wr_ctrl,
    output logic [2:0]            wt_col,
    output logic [DATA_WIDTH-1:0] wt_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
`ifdef ACCEL_WLOAD_STALL_CNT_EN
    ,
    output logic [15:0]           wload_stall_cycles
`endif
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [3:0]            MAX_R     = 4'(PE_ROWS);
    localparam logic [3:0]            MAX_S     = 4'(PE_COLS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    logic [2:0]            state_d, state_q;
    logic [3:0]            r_d, r_q;
    logic [3:0]            s_d, s_q;
    logic [2:0]            row_d, row_q;
    logic [2:0]            col_d, col_q;
    logic [ADDR_WIDTH-1:0] addr_d, addr_q;
    logic                  rd_req_valid_d, rd_req_valid_q;
    logic [ADDR_WIDTH-1:0] rd_req_addr_d, rd_req_addr_q;
    logic                  wt_wr_en_d, wt_wr_en_q;
    logic [2:0]            wt_row_d, wt_row_q;
    logic [2:0]            wt_col_d, wt_col_q;
    logic [DATA_WIDTH-1:0] wt_data_d, wt_data_q;
    logic                  busy_d, busy_q;
    logic                  done_d, done_q;
    logic                  err_d, err_q;
    logic                  params_bad_s;
    logic                  last_col_s;
    logic                  last_row_s;

    // Parameter legality and position decode for the current word.
    always_comb begin
        params_bad_s = (param_R == 4'd0) || (param_R > MAX_R) ||
                       (param_S == 4'd0) || (param_S > MAX_S);
        last_col_s   = ({1'b0, col_q} == (s_q - 4'd1));
        last_row_s   = ({1'b0, row_q} == (r_q - 4'd1));
    end

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        s_d         = s_q;
        row_d       = row_q;
        col_d       = col_q;
        addr_d      = addr_q;
        err_d       = err_q;
        wt_wr_en_d  = 1'b0;
        wt_row_d    = 3'd0;
        wt_col_d    = 3'd0;
        wt_data_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    r_d    = param_R;
                    s_d    = param_S;
                    row_d  = 3'd0;
                    col_d  = 3'd0;
                    addr_d = weight_base_addr;
                    if (params_bad_s) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_REQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (rd_req_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                // The response word goes straight into the write register,
                // so the WRITE cycle presents it without extra storage.
                if (rd_rsp_valid) begin
                    state_d    = ST_WRITE;
                    wt_wr_en_d = 1'b1;
                    wt_row_d   = row_q;
                    wt_col_d   = col_q;
                    wt_data_d  = rd_rsp_data;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WRITE: begin
                if (last_row_s && last_col_s) begin
                    state_d = ST_DONE;
                end else begin
                    if (last_col_s) begin
                        col_d = 3'd0;
                        row_d = row_q + 3'd1;
                    end else begin
                        col_d = col_q + 3'd1;
                        row_d = row_q;
                    end
                    addr_d  = addr_q + ADDR_STEP;
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake and status outputs are decoded from the next state so
        // they leave a flop aligned with the state they describe.
        rd_req_valid_d = (state_d == ST_REQ);
        rd_req_addr_d  = (state_d == ST_REQ) ? addr_d : '0;
        busy_d         = (state_d != ST_IDLE);
        done_d         = (state_d == ST_DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q        <= ST_IDLE;
            r_q            <= 4'd0;
            s_q            <= 4'd0;
            row_q          <= 3'd0;
            col_q          <= 3'd0;
            addr_q         <= '0;
            rd_req_valid_q <= 1'b0;
            rd_req_addr_q  <= '0;
            wt_wr_en_q     <= 1'b0;
            wt_row_q       <= 3'd0;
            wt_col_q       <= 3'd0;
            wt_data_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            r_q            <= r_d;
            s_q            <= s_d;
            row_q          <= row_d;
            col_q          <= col_d;
            addr_q         <= addr_d;
            rd_req_valid_q <= rd_req_valid_d;
            rd_req_addr_q  <= rd_req_addr_d;
            wt_wr_en_q     <= wt_wr_en_d;
            wt_row_q       <= wt_row_d;
            wt_col_q       <= wt_col_d;
            wt_data_q      <= wt_data_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    assign rd_req_valid       = rd_req_valid_q;
    assign rd_req_addr        = rd_req_addr_q;
    assign wt_wr_en           = wt_wr_en_q;
    assign weight_row_wr_ctrl = wt_row_q;
    assign wt_col             = wt_col_q;
    assign wt_data            = wt_data_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign err                = err_q;

`ifdef ACCEL_WLOAD_STALL_CNT_EN
    logic [15:0] stall_d, stall_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc16 = v;
        end else begin
            sat_inc16 = v + 16'd1;
        end
    endfunction

    // Back-pressure counter: request not accepted or response not yet back.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_IDLE) && start) begin
            stall_d = 16'd0;
        end else if (((state_q == ST_REQ) && !rd_req_ready) ||
                     ((state_q == ST_WAIT) && !rd_rsp_valid)) begin
            stall_d = sat_inc16(stall_q);
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign wload_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_accel_weight_load_seq.sv
// Directed bench for accel_weight_load_seq with a one-outstanding memory
// responder whose ready back-pressure and response latency are steerable
// per word index.

module tb_accel_weight_load_seq;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  param_R = 4'd0;
    logic [3:0]  param_S = 4'd0;
    logic [31:0] weight_base_addr = 32'd0;
    logic        rd_req_valid;
    logic        rd_req_ready = 1'b0;
    logic [31:0] rd_req_addr;
    logic        rd_rsp_valid = 1'b0;
    logic [31:0] rd_rsp_data = 32'd0;
    logic        wt_wr_en;
    logic [2:0]  weight_row_wr_ctrl;
    logic [2:0]  wt_col;
    logic [31:0] wt_data;
    logic        busy;
    logic        done;
    logic        err;
`ifdef ACCEL_WLOAD_STALL_CNT_EN
    logic [15:0] wload_stall_cycles;
`endif

    accel_weight_load_seq dut (
        .CLK                (CLK),
        .RESETN             (RESETN),
        .start              (start),
        .param_R            (param_R),
        .param_S            (param_S),
        .weight_base_addr   (weight_base_addr),
        .rd_req_valid       (rd_req_valid),
        .rd_req_ready       (rd_req_ready),
        .rd_req_addr        (rd_req_addr),
        .rd_rsp_valid       (rd_rsp_valid),
        .rd_rsp_data        (rd_rsp_data),
        .wt_wr_en           (wt_wr_en),
        .weight_row_wr_ctrl (weight_row_wr_ctrl),
        .wt_col             (wt_col),
        .wt_data            (wt_data),
        .busy               (busy),
        .done               (done),
        .err                (err)
`ifdef ACCEL_WLOAD_STALL_CNT_EN
        ,
        .wload_stall_cycles (wload_stall_cycles)
`endif
    );

    always #5 CLK = ~CLK;

    int edge_cnt = 0;
    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        mem_word = 32'hA5C3_0000 ^ (a * 32'd7) ^ 32'h0000_1234;
    endfunction

    // Recorders and responder controls (owned by the negedge loop below).
    int          t0 = 0;
    int          wr_cnt = 0, acc_cnt = 0, done_cnt = 0, done_cyc = -1;
    int          zero_viol = 0, low_cnt = 0, rsp_cnt = 0;
    int          stall_word = -1, stall_len = 0, dly_word = -1, dly_len = 0;
    logic        req_seen = 1'b0, pend = 1'b0, done_err = 1'b0;
    logic [31:0] pend_addr = 32'd0, base_cur = 32'd0;
    logic [2:0]  wr_row [0:31];
    logic [2:0]  wr_col [0:31];
    logic [31:0] wr_data[0:31];
    int          wr_cyc [0:31];
    logic [31:0] acc_addr[0:31];

    // Output monitor plus memory responder, evaluated away from the active edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (done) begin
                done_cnt++;
                done_cyc = edge_cnt - t0;
                done_err = err;
            end
            if (rd_req_valid) req_seen = 1'b1;
            if (wt_wr_en) begin
                if (wr_cnt < 32) begin
                    wr_row[wr_cnt]  = weight_row_wr_ctrl;
                    wr_col[wr_cnt]  = wt_col;
                    wr_data[wr_cnt] = wt_data;
                    wr_cyc[wr_cnt]  = edge_cnt - t0;
                end
                wr_cnt++;
            end else if (weight_row_wr_ctrl != 3'd0 || wt_col != 3'd0 || wt_data != 32'd0) begin
                zero_viol++;
            end
            if (pend && rsp_cnt == 0) begin
                rd_rsp_valid = 1'b1;
                rd_rsp_data  = mem_word(pend_addr);
                pend = 1'b0;
            end else begin
                rd_rsp_valid = 1'b0;
                rd_rsp_data  = 32'd0;
                if (pend) rsp_cnt--;
            end
            if (rd_req_valid) begin
                if (acc_cnt == stall_word && low_cnt < stall_len) begin
                    rd_req_ready = 1'b0;
                    low_cnt++;
                    check_eq("req_addr_held", rd_req_addr, base_cur + 32'(4 * acc_cnt));
                end else begin
                    rd_req_ready = 1'b1;
                    if (acc_cnt < 32) acc_addr[acc_cnt] = rd_req_addr;
                    rsp_cnt   = (acc_cnt == dly_word) ? dly_len : 0;
                    acc_cnt++;
                    pend      = 1'b1;
                    pend_addr = rd_req_addr;
                end
            end else begin
                rd_req_ready = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic start_load(input logic [3:0] r, input logic [3:0] s, input logic [31:0] base,
                              input int sw, input int sl, input int dw, input int dl);
        tick(1);
        wr_cnt = 0; acc_cnt = 0; done_cnt = 0; done_cyc = -1; zero_viol = 0;
        low_cnt = 0; req_seen = 1'b0; done_err = 1'b0; base_cur = base;
        stall_word = sw; stall_len = sl; dly_word = dw; dly_len = dl;
        param_R = r; param_S = s; weight_base_addr = base;
        start = 1'b1;
        t0 = edge_cnt;
        tick(1);
        start = 1'b0;
        param_R = 4'd0; param_S = 4'd0; weight_base_addr = 32'hDEAD_BEEF;
    endtask

    task automatic wait_done(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (done_cnt > 0) break;
            tick(1);
        end
        check_eq("done_seen", 64'(done_cnt), 64'd1);
    endtask

    task automatic check_writes(input string tag, input int n, input logic [3:0] s, input logic [31:0] base);
        check_eq({tag, "_wr_cnt"}, 64'(wr_cnt), 64'(n));
        for (int k = 0; k < n; k++) begin
            check_eq({tag, "_addr"}, acc_addr[k], base + 32'(4 * k));
            check_eq({tag, "_row"},  64'(wr_row[k]), 64'(k / int'(s)));
            check_eq({tag, "_col"},  64'(wr_col[k]), 64'(k % int'(s)));
            check_eq({tag, "_data"}, wr_data[k], mem_word(base + 32'(4 * k)));
        end
        check_eq({tag, "_idle_zero"}, 64'(zero_viol), 64'd0);
    endtask

    initial begin
        // Reset state
        tick(2);
        check_eq("rst_ctrl", {rd_req_valid, wt_wr_en, busy, done, err, weight_row_wr_ctrl, wt_col}, 64'd0);
        check_eq("rst_addr", rd_req_addr, 32'd0);
        check_eq("rst_data", wt_data, 32'd0);
        RESETN = 1'b1;
        tick(2);
        check_eq("idle_busy", busy, 1'b0);

        // 3x3, zero-latency memory
        start_load(4'd3, 4'd3, 32'h1000, -1, 0, -1, 0);
        wait_done(200);
        check_eq("t1_done_cyc", 64'(done_cyc), 64'd28);
        check_eq("t1_err", done_err, 1'b0);
        check_eq("t1_first_cyc", 64'(wr_cyc[0]), 64'd3);
        check_eq("t1_last_cyc", 64'(wr_cyc[8]), 64'd27);
        check_writes("t1", 9, 4'd3, 32'h1000);
        tick(1);
        check_eq("t1_busy_after", busy, 1'b0);

        // 3x3 with ready low for 4 cycles on word 2
        start_load(4'd3, 4'd3, 32'h1000, 2, 4, -1, 0);
        wait_done(200);
        check_eq("t2_done_cyc", 64'(done_cyc), 64'd32);
        check_eq("t2_low_cycles", 64'(low_cnt), 64'd4);
        check_writes("t2", 9, 4'd3, 32'h1000);

        // Illegal parameters, then a legal load clears err
        start_load(4'd6, 4'd2, 32'h2000, -1, 0, -1, 0);
        wait_done(50);
        check_eq("t3_done_cyc", 64'(done_cyc), 64'd1);
        check_eq("t3_err", done_err, 1'b1);
        check_eq("t3_no_req", req_seen, 1'b0);
        check_eq("t3_no_wr", 64'(wr_cnt), 64'd0);
        tick(2);
        check_eq("t3_err_sticky", err, 1'b1);
        start_load(4'd1, 4'd1, 32'h2000, -1, 0, -1, 0);
        check_eq("t3_err_cleared", err, 1'b0);
        wait_done(50);
        check_eq("t3b_done_cyc", 64'(done_cyc), 64'd4);
        check_writes("t3b", 1, 4'd1, 32'h2000);

        // Second start during a busy 2x2 load is ignored
        start_load(4'd2, 4'd2, 32'h3000, -1, 0, -1, 0);
        tick(3);
        param_R = 4'd1; param_S = 4'd1; weight_base_addr = 32'h9000;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(100);
        tick(10);
        check_eq("t4_done_pulses", 64'(done_cnt), 64'd1);
        check_eq("t4_done_cyc", 64'(done_cyc), 64'd13);
        check_writes("t4", 4, 4'd2, 32'h3000);

        // Reset in mid-WAIT after the 4th write, with a late response
        start_load(4'd3, 4'd3, 32'h4000, -1, 0, 4, 3);
        for (int i = 0; i < 100; i++) begin
            if (wr_cnt >= 4) break;
            tick(1);
        end
        check_eq("t5_four_writes", 64'(wr_cnt), 64'd4);
        tick(2);
        check_eq("t5_in_wait", {busy, rd_req_valid, wt_wr_en}, 3'b100);
        RESETN = 1'b0;
        #1;
        check_eq("t5_rst_ctrl", {rd_req_valid, wt_wr_en, busy, done, err, weight_row_wr_ctrl, wt_col}, 64'd0);
        check_eq("t5_rst_addr", rd_req_addr, 32'd0);
        check_eq("t5_rst_data", wt_data, 32'd0);
        tick(2);
        RESETN = 1'b1;
        tick(6);
        check_eq("t5_no_extra_wr", 64'(wr_cnt), 64'd4);
        check_eq("t5_idle", {busy, rd_req_valid, done}, 3'b000);
        start_load(4'd3, 4'd3, 32'h4000, -1, 0, -1, 0);
        wait_done(200);
        check_eq("t5b_done_cyc", 64'(done_cyc), 64'd28);
        check_writes("t5b", 9, 4'd3, 32'h4000);

`ifdef ACCEL_WLOAD_STALL_CNT_EN
        // Stall counter: 4 ready-low cycles plus 2 response-wait cycles
        start_load(4'd2, 4'd2, 32'h5000, 1, 4, 2, 2);
        wait_done(100);
        tick(2);
        check_eq("t6_done_cyc", 64'(done_cyc), 64'd19);
        check_eq("t6_stall_cycles", 64'(wload_stall_cycles), 64'd6);
        check_writes("t6", 4, 4'd2, 32'h5000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/accel_weight_load_seq.md
Name: accel_weight_load_seq

Overview:
Sequences the loading of one R x S filter into the PE array weight registers. On a start pulse it fetches R*S weight words, one outstanding request at a time, over a valid/ready read-request and valid-response memory interface. It then writes each word into the array using row and column select signals. It sits between the accelerator control unit, which supplies params, base address and start, and the PE array weight-write port.

Parameters:
DATA_WIDTH, 32, weight word width (wt_data, rd_rsp_data)
ADDR_WIDTH, 32, memory address width
PE_ROWS, 5, PE array rows; upper bound for param_R
PE_COLS, 5, PE array columns; upper bound for param_S

Ports:
CLK  in  1  clock
RESETN  in  1  asynchronous, active-low reset
start  in  1  request a load; sampled only in IDLE
param_R  in  4  filter rows to load; legal range 1..PE_ROWS
param_S  in  4  filter columns per row; legal range 1..PE_COLS
weight_base_addr  in  ADDR_WIDTH  byte address of weight (0,0)
rd_req_valid  out  1  read request valid
rd_req_ready  in  1  memory accepts request
rd_req_addr  out  ADDR_WIDTH  read byte address
rd_rsp_valid  in  1  read data valid
rd_rsp_data  in  DATA_WIDTH  read data
wt_wr_en  out  1  one-cycle PE weight write strobe
weight_row_wr_ctrl  out  3  PE row index being written
wt_col  out  3  PE column index being written
wt_data  out  DATA_WIDTH  weight value
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  sticky illegal-parameter flag

Behaviour:
- Reset (async assert, sync release): FSM goes to IDLE; every output is 0; internal row, column and address counters are 0. A response arriving after reset is ignored.
- States:
  - IDLE -> REQ or DONE
  - REQ -> WAIT
  - WAIT -> WRITE
  - WRITE -> REQ or DONE
  - DONE -> IDLE
- IDLE, start=1:
  - Latch param_R, param_S and weight_base_addr. Inputs are not sampled again until the next IDLE.
  - Clear err.
  - If R=0, R>PE_ROWS, S=0 or S>PE_COLS: set err=1 and go to DONE. No memory request is issued.
  - Otherwise go to REQ with row=0, col=0, addr=base.
- start outside IDLE is ignored.
- REQ:
  - rd_req_valid=1 and rd_req_addr=addr.
  - Both are held stable until rd_req_ready=1 in the same cycle, then go to WAIT.
- WAIT:
  - The first cycle with rd_rsp_valid=1 captures rd_rsp_data and goes to WRITE.
  - rd_rsp_valid in any other state is ignored.
- WRITE:
  - wt_wr_en=1 for exactly one cycle, with weight_row_wr_ctrl=row, wt_col=col and wt_data=captured word.
  - If row=R-1 and col=S-1: go to DONE.
  - Otherwise col increments, wrapping to 0 at S with row+1; addr += DATA_WIDTH/8, modulo 2^ADDR_WIDTH; go to REQ.
- Addressing is row-major and dense: addr = base + (DATA_WIDTH/8)*(row*S + col).
- DONE: done=1 for one cycle, then IDLE. err stays high until the next accepted start.
- wt_wr_en, weight_row_wr_ctrl, wt_col and wt_data are registered; row, col and data are 0 whenever wt_wr_en=0.
- Timing with zero memory latency (ready=1, response the cycle after acceptance):
  - Each word takes 3 cycles.
  - With start accepted at cycle 0, word k is written at cycle 3k+3 and done is high at cycle 3*R*S+1.
  - An illegal-parameter start gives done at cycle 1.

Optional Feature:
ACCEL_WLOAD_STALL_CNT_EN
- Defined:
  - Adds output wload_stall_cycles [15:0].
  - Counts cycles in REQ with rd_req_ready=0 plus cycles in WAIT with rd_rsp_valid=0.
  - Saturates at 0xFFFF, clears to 0 on an accepted start, holds its value after DONE, and resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- R=3, S=3, base=0x1000, ready=1, response one cycle after acceptance -> 9 writes in order (0,0)..(2,2); addresses 0x1000..0x1020 in steps of 4; wt_data matches memory; done at cycle 28; err=0.
- Same load with rd_req_ready held low for 4 cycles on word 2 -> rd_req_addr=0x1008 stable for all 5 REQ cycles; no extra writes; done at cycle 32.
- R=6, S=2 (illegal) -> err=1, done at cycle 1, rd_req_valid never asserted; a following legal start clears err.
- start pulsed again during the busy load of R=2, S=2 -> ignored; exactly 4 writes and one done pulse.
- RESETN driven low after the 4th write of a 3x3 load, in mid-WAIT -> all outputs 0 immediately, busy=0; a late rd_rsp_valid is ignored; a new start reloads from base with (0,0).
- ACCEL_WLOAD_STALL_CNT_EN defined, 2x2 load with 4 ready-low cycles and one response delayed by 2 cycles -> wload_stall_cycles=6 after done.
